// File: rtl/gb_baz_pkg.sv
// Shared address map and reset constants for the gb_baz_node Ghostbus slave.
package gb_baz_pkg;

  localparam logic [6:0] ADDR_ID      = 7'h00;
  localparam logic [6:0] ADDR_CTRL    = 7'h01;
  localparam logic [6:0] ADDR_STATUS  = 7'h02;
  localparam logic [6:0] ADDR_SCRATCH = 7'h03;
  localparam logic [6:0] ADDR_WCOUNT  = 7'h04;
  localparam logic [6:0] RAM_BASE     = 7'h20;
  localparam logic [6:0] EXT_BASE     = 7'h40;

  localparam logic [31:0] ID_VALUE   = 32'hBA20_0001;
  localparam logic [7:0]  CTRL_RESET = 8'h42;

endpackage

// File: rtl/gb_baz_ram.sv
// 32-entry local RAM: one synchronous write port, one asynchronous read port.
module gb_baz_ram #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [4:0]    waddr,
  input  logic [DW-1:0] wdata,
  input  logic [4:0]    raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [32];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/gb_baz_node.sv
// Ghostbus slave node: CSR bank, 32-word RAM and an optional external bridge
// at 0x40-0x7F, enabled by defining BAZ_EXT_BRIDGE_EN.
module gb_baz_node
  import gb_baz_pkg::*;
#(
  parameter int AW = 12,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          demo_sig,
  input  logic          GBPORT_clk,
  input  logic [23:0]   GBPORT_addr,
  input  logic [31:0]   GBPORT_dout,
  output logic [31:0]   GBPORT_din,
  input  logic          GBPORT_we,
  input  logic          GBPORT_wstb,
  input  logic          GBPORT_rstb,
  output logic [5:0]    ext_addr,
  output logic [DW-1:0] ext_wdata,
  output logic          ext_we,
  input  logic [DW-1:0] ext_rdata
);

  logic [6:0]    a;
  logic          wr;
  logic          ram_hit;
  logic          ext_hit;
  logic          count_hit;
  logic          ram_we;
  logic [7:0]    ctrl_q;
  logic [DW-1:0] scratch_q;
  logic [15:0]   wcount_q;
  logic          status_q;
  logic [DW-1:0] ram_rdata;
  logic [31:0]   rd_data;
  logic          sink_unused;

  assign a       = GBPORT_addr[6:0];
  assign wr      = GBPORT_we & GBPORT_wstb;
  assign ram_hit = (a[6:5] == RAM_BASE[6:5]);

`ifdef BAZ_EXT_BRIDGE_EN
  assign ext_hit   = a[6];
  assign ext_addr  = a[5:0];
  assign ext_wdata = GBPORT_dout[DW-1:0];
  assign ext_we    = wr & a[6] & ~rst;
`else
  assign ext_hit   = 1'b0;
  assign ext_addr  = '0;
  assign ext_wdata = '0;
  assign ext_we    = 1'b0;
`endif

  assign count_hit = wr & ((a == ADDR_CTRL) | (a == ADDR_SCRATCH) | ram_hit | ext_hit);
  // A concurrent reset overrides the access, RAM included.
  assign ram_we    = wr & ram_hit & ~rst;

  // Only the low 7 address bits are decoded; the bus clock mirrors clk.
  assign sink_unused = ^{GBPORT_clk, GBPORT_addr[23:7], GBPORT_dout, ext_rdata, AW[0]};

  gb_baz_ram #(
    .DW(DW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(a[4:0]),
    .wdata(GBPORT_dout[DW-1:0]),
    .raddr(a[4:0]),
    .rdata(ram_rdata)
  );

  always_comb begin
    rd_data = '0;
    if (ram_hit) begin
      rd_data = 32'(ram_rdata);
    end else if (ext_hit) begin
      rd_data = 32'(ext_rdata);
    end else begin
      case (a)
        ADDR_ID:      rd_data = ID_VALUE;
        ADDR_CTRL:    rd_data = 32'(ctrl_q);
        ADDR_STATUS:  rd_data = {30'd0, ctrl_q[0], status_q};
        ADDR_SCRATCH: rd_data = 32'(scratch_q);
        ADDR_WCOUNT:  rd_data = 32'(wcount_q);
        default:      rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q     <= CTRL_RESET;
      scratch_q  <= '0;
      wcount_q   <= '0;
      status_q   <= 1'b0;
      GBPORT_din <= '0;
    end else begin
      status_q <= demo_sig;
      if (GBPORT_rstb) begin
        GBPORT_din <= rd_data;
      end
      if (wr && (a == ADDR_CTRL)) begin
        ctrl_q <= GBPORT_dout[7:0];
      end
      if (wr && (a == ADDR_SCRATCH)) begin
        scratch_q <= GBPORT_dout[DW-1:0];
      end
      if (count_hit) begin
        wcount_q <= wcount_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_gb_baz_node.sv
// Randomized self-checking bench for gb_baz_node against a behavioural register-map model.
module tb_gb_baz_node;

  localparam int DW = 8;
`ifdef BAZ_EXT_BRIDGE_EN
  localparam bit BR_EN = 1'b1;
`else
  localparam bit BR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          demo_sig;
  logic          GBPORT_clk;
  logic [23:0]   GBPORT_addr;
  logic [31:0]   GBPORT_dout;
  logic [31:0]   GBPORT_din;
  logic          GBPORT_we;
  logic          GBPORT_wstb;
  logic          GBPORT_rstb;
  logic [5:0]    ext_addr;
  logic [DW-1:0] ext_wdata;
  logic          ext_we;
  logic [DW-1:0] ext_rdata;

  int n_run  = 0;
  int n_fail = 0;

  // Behavioural model state
  logic [7:0]    ctrl_m;
  logic [DW-1:0] scr_m;
  logic [15:0]   wc_m;
  logic          st_m;
  logic [31:0]   din_m;
  logic [DW-1:0] ram_m [32];
  logic [DW-1:0] ext_m [64];
  logic          demo_cur;

  // External memory-like device
  logic [DW-1:0] ext_dev [64];
  assign ext_rdata = ext_dev[ext_addr];
  always @(posedge clk) if (ext_we) ext_dev[ext_addr] <= ext_wdata;

  always #5 clk = ~clk;
  assign GBPORT_clk = clk;

  gb_baz_node #(
    .AW(12),
    .DW(DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .demo_sig   (demo_sig),
    .GBPORT_clk (GBPORT_clk),
    .GBPORT_addr(GBPORT_addr),
    .GBPORT_dout(GBPORT_dout),
    .GBPORT_din (GBPORT_din),
    .GBPORT_we  (GBPORT_we),
    .GBPORT_wstb(GBPORT_wstb),
    .GBPORT_rstb(GBPORT_rstb),
    .ext_addr   (ext_addr),
    .ext_wdata  (ext_wdata),
    .ext_we     (ext_we),
    .ext_rdata  (ext_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [6:0] a);
    if (a >= 7'h40) return BR_EN ? 32'(ext_m[a[5:0]]) : 32'd0;
    if (a >= 7'h20) return 32'(ram_m[a[4:0]]);
    case (a)
      7'h00:   return 32'hBA20_0001;
      7'h01:   return 32'(ctrl_m);
      7'h02:   return {30'd0, ctrl_m[0], st_m};
      7'h03:   return 32'(scr_m);
      7'h04:   return 32'(wc_m);
      default: return 32'd0;
    endcase
  endfunction

  // One bus cycle: drive at negedge, check combinational bridge outputs, then check din after edge.
  task automatic step(input logic r, input logic we, input logic wstb, input logic rstb,
                      input logic [6:0] a, input logic [31:0] d);
    logic [31:0] rv;
    logic        wr;
    @(negedge clk);
    rst         = r;
    GBPORT_we   = we;
    GBPORT_wstb = wstb;
    GBPORT_rstb = rstb;
    GBPORT_addr = {17'($urandom()), a};
    GBPORT_dout = d;
    demo_sig    = demo_cur;
    #1;
    wr = we & wstb;
    check("ext_we", 32'(ext_we), 32'(BR_EN & ~r & wr & a[6]));
    check("ext_addr", 32'(ext_addr), BR_EN ? 32'(a[5:0]) : 32'd0);
    check("ext_wdata", 32'(ext_wdata), BR_EN ? 32'(d[DW-1:0]) : 32'd0);
    rv = model_read(a);
    @(posedge clk);
    #1;
    if (r) begin
      din_m  = 32'd0;
      ctrl_m = 8'h42;
      scr_m  = '0;
      wc_m   = 16'd0;
      st_m   = 1'b0;
    end else begin
      if (rstb) din_m = rv;
      if (wr) begin
        if (a == 7'h01) begin
          ctrl_m = d[7:0];
          wc_m   = wc_m + 16'd1;
        end else if (a == 7'h03) begin
          scr_m = d[DW-1:0];
          wc_m  = wc_m + 16'd1;
        end else if (a >= 7'h20 && a < 7'h40) begin
          ram_m[a[4:0]] = d[DW-1:0];
          wc_m          = wc_m + 16'd1;
        end else if (a >= 7'h40 && BR_EN) begin
          ext_m[a[5:0]] = d[DW-1:0];
          wc_m          = wc_m + 16'd1;
        end
      end
      st_m = demo_cur;
    end
    check("din", GBPORT_din, din_m);
  endtask

  task automatic rd(input logic [6:0] a);
    step(1'b0, 1'b0, $urandom_range(0, 1), 1'b1, a, $urandom());
  endtask

  task automatic wrt(input logic [6:0] a, input logic [31:0] d);
    step(1'b0, 1'b1, 1'b1, 1'b0, a, d);
  endtask

  initial begin
    logic [6:0] ra;
    int         sel;
    for (int i = 0; i < 32; i++) ram_m[i] = '0;
    for (int i = 0; i < 64; i++) ext_m[i] = '0;
    ctrl_m = 8'h42; scr_m = '0; wc_m = 16'd0; st_m = 1'b0; din_m = 32'd0;
    demo_cur = 1'b0;
    rst = 1'b1; GBPORT_we = 1'b0; GBPORT_wstb = 1'b0; GBPORT_rstb = 1'b0;
    GBPORT_addr = '0; GBPORT_dout = '0; demo_sig = 1'b0;

    // Reset overrides a concurrent read
    step(1'b1, 1'b0, 1'b0, 1'b1, 7'h00, 32'd0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 7'h01, 32'h0000_0011);
    check("rst_din", GBPORT_din, 32'd0);

    rd(7'h00); check("id", GBPORT_din, 32'hBA20_0001);
    rd(7'h01); check("ctrl_rst", GBPORT_din, 32'h0000_0042);
    rd(7'h04); check("wcount_rst", GBPORT_din, 32'd0);

    wrt(7'h03, 32'hFFFF_FFA5);
    rd(7'h03); check("scratch", GBPORT_din, 32'h0000_00A5);
    rd(7'h04); check("wcount_1", GBPORT_din, 32'd1);

    demo_cur = 1'b1;
    wrt(7'h2A, 32'h0000_005C);
    wrt(7'h02, 32'h0000_0077);
    rd(7'h2A); check("ram_2a", GBPORT_din, 32'h0000_005C);
    rd(7'h02); check("status", GBPORT_din, 32'h0000_0001);
    rd(7'h04); check("wcount_ro_drop", GBPORT_din, 32'd2);

    wrt(7'h45, 32'h0000_003C);
    rd(7'h45); check("bridge_rd", GBPORT_din, BR_EN ? 32'h0000_003C : 32'd0);

    // Same-cycle write and read returns the old value
    step(1'b0, 1'b1, 1'b1, 1'b1, 7'h01, 32'h0000_0010);
    check("rw_same", GBPORT_din, 32'h0000_0042);
    rd(7'h01); check("rw_after", GBPORT_din, 32'h0000_0010);

    step(1'b1, 1'b0, 1'b0, 1'b0, 7'h00, 32'd0);
    rd(7'h01); check("ctrl_rst2", GBPORT_din, 32'h0000_0042);
    rd(7'h04); check("wcount_rst2", GBPORT_din, 32'd0);
    rd(7'h2A); check("ram_persist", GBPORT_din, 32'h0000_005C);

    // Give every RAM and bridge word a known value before random traffic
    for (int i = 0; i < 32; i++) wrt(7'(32 + i), $urandom());
    for (int i = 0; i < 64; i++) wrt(7'(64 + i), $urandom());

    for (int i = 0; i < 2000; i++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 4)      ra = 7'(sel);
      else if (sel == 5) ra = 7'($urandom_range(5, 31));
      else if (sel <= 7) ra = 7'($urandom_range(32, 63));
      else               ra = 7'($urandom_range(64, 127));
      demo_cur = 1'($urandom());
      step(($urandom_range(0, 49) == 0), 1'($urandom()), 1'($urandom()), 1'($urandom()),
           ra, $urandom());
    end

    // Write counter wrap
    step(1'b1, 1'b0, 1'b0, 1'b0, 7'h00, 32'd0);
    for (int i = 0; i < 65536; i++) wrt(7'h03, $urandom());
    rd(7'h04); check("wcount_wrap", GBPORT_din, 32'd0);
    rd(7'h45);
    rd(7'h04); check("wcount_after_bridge", GBPORT_din, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
